// File: rtl/exc_pkg.sv
// Shared definitions for the exception sequencer.
//   exc_state_t    : sequencer FSM states
//   CAUSE_OVF      : cause code recorded for an arithmetic overflow
//   VECTOR_DEFAULT : default service-bank entry address
package exc_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        SERVICE = 2'd1,
        RETURN  = 2'd2,
        HALT    = 2'd3
    } exc_state_t;

    localparam logic [3:0] CAUSE_OVF      = 4'hC;
    localparam int         VECTOR_DEFAULT = 0;

endpackage

// File: rtl/irq_priority_encoder.sv
// Masked lowest-index interrupt select.
//   i_req   : pending & mask, one bit per line
//   o_valid : at least one request present
//   o_idx   : index of the lowest requesting line (0 when none)
module irq_priority_encoder #(
    parameter int NUM_IRQ = 4
) (
    input  logic [NUM_IRQ-1:0] i_req,
    output logic               o_valid,
    output logic [2:0]         o_idx
);

    // Scan from the top down so the lowest set index is the last write.
    always_comb begin
        o_valid = 1'b0;
        o_idx   = 3'd0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                o_valid = 1'b1;
                o_idx   = 3'(i);
            end
        end
    end

endmodule

// File: rtl/exception_sequencer.sv
// Fetch-side controller for the banked instruction memory. Owns the fetch PC
// and the bank select, latches interrupts, takes overflow/IRQ events into the
// service bank and returns on ERET.
//   clk, reset         : clock, asynchronous active-high reset
//   pc_next            : datapath next PC for the current instruction
//   irq                : single-cycle interrupt pulses
//   ovf_exc, eret      : overflow of current instruction / ERET decode
//   mask_we, mask_wdata: interrupt mask write (1 enables a line)
//   pc, bank_sel       : fetch address and bank (0 program, 1 service)
//   flush              : kill writeback of the current instruction
//   epc, cause         : saved return address and last event code
//   pending, halted    : latched requests, double-fault flag
module exception_sequencer
    import exc_pkg::*;
#(
    parameter int NUM_IRQ = 4,
    parameter int ADDR_W  = 9,
    parameter int VECTOR  = VECTOR_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] pc_next,
    input  logic [NUM_IRQ-1:0] irq,
    input  logic              ovf_exc,
    input  logic              eret,
    input  logic              mask_we,
    input  logic [NUM_IRQ-1:0] mask_wdata,
    output logic [ADDR_W-1:0] pc,
    output logic              bank_sel,
    output logic              flush,
    output logic [ADDR_W-1:0] epc,
    output logic [3:0]        cause,
    output logic [NUM_IRQ-1:0] pending,
    output logic              halted
);

    localparam logic [ADDR_W-1:0] VEC_ADDR = ADDR_W'(VECTOR);

    exc_state_t         r_state, w_state_nxt;
    logic [ADDR_W-1:0]  r_pc, w_pc_nxt;
    logic               r_bank, w_bank_nxt;
    logic [ADDR_W-1:0]  r_epc, w_epc_nxt;
    logic [3:0]         r_cause, w_cause_nxt;
    logic               r_halted, w_halted_nxt;
    logic [NUM_IRQ-1:0] r_mask;
    logic [NUM_IRQ-1:0] r_pending;
    logic [NUM_IRQ-1:0] w_clr;
    logic               w_flush;
    logic               w_take;
    logic               w_enc_valid;
    logic [2:0]         w_enc_idx;

    // Takes are decided from the registered pending bits, so an IRQ pulse
    // is visible in pending one cycle before it can redirect fetch.
    irq_priority_encoder #(.NUM_IRQ(NUM_IRQ)) u_enc (
        .i_req   (r_pending & r_mask),
        .o_valid (w_enc_valid),
        .o_idx   (w_enc_idx)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= RUN;
            r_pc     <= '0;
            r_bank   <= 1'b0;
            r_epc    <= '0;
            r_cause  <= 4'd0;
            r_halted <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_pc     <= w_pc_nxt;
            r_bank   <= w_bank_nxt;
            r_epc    <= w_epc_nxt;
            r_cause  <= w_cause_nxt;
            r_halted <= w_halted_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_pc_nxt     = r_pc;
        w_bank_nxt   = r_bank;
        w_epc_nxt    = r_epc;
        w_cause_nxt  = r_cause;
        w_halted_nxt = r_halted;
        w_flush      = 1'b0;
        w_take       = 1'b0;
        case (r_state)
            RUN, RETURN: begin
                w_pc_nxt    = pc_next;
                w_state_nxt = RUN;
                if (ovf_exc) begin
                    // Faulting instruction is killed and re-executed on return.
                    w_flush     = 1'b1;
                    w_epc_nxt   = r_pc;
                    w_cause_nxt = CAUSE_OVF;
                    w_pc_nxt    = VEC_ADDR;
                    w_bank_nxt  = 1'b1;
                    w_state_nxt = SERVICE;
                end else if (r_state == RUN && w_enc_valid) begin
                    // Current instruction completes; resume after it.
                    w_take      = 1'b1;
                    w_epc_nxt   = pc_next;
                    w_cause_nxt = {1'b0, w_enc_idx};
                    w_pc_nxt    = VEC_ADDR;
                    w_bank_nxt  = 1'b1;
                    w_state_nxt = SERVICE;
                end
            end
            SERVICE: begin
                if (ovf_exc) begin
                    // Double fault: PC stays on the faulting handler address.
                    w_flush      = 1'b1;
                    w_halted_nxt = 1'b1;
                    w_state_nxt  = HALT;
                end else if (eret) begin
                    w_pc_nxt    = r_epc;
                    w_bank_nxt  = 1'b0;
                    w_state_nxt = RETURN;
                end else begin
                    w_pc_nxt = pc_next;
                end
            end
            default: begin
                w_flush = 1'b1;
            end
        endcase
    end

    always_comb begin
        w_clr = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            w_clr[i] = w_take && (w_enc_idx == 3'(i));
        end
    end

    // New requests OR in after the clear, so a set wins over a same-cycle take.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pending <= '0;
            r_mask    <= '0;
        end else begin
            r_pending <= (r_pending & ~w_clr) | irq;
            if (mask_we) r_mask <= mask_wdata;
        end
    end

    assign pc       = r_pc;
    assign bank_sel = r_bank;
    assign flush    = w_flush;
    assign epc      = r_epc;
    assign cause    = r_cause;
    assign pending  = r_pending;
    assign halted   = r_halted;

endmodule

// File: tb/tb_exception_sequencer.sv
module tb_exception_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [8:0] pc_next = '0;
    logic [3:0] irq = '0;
    logic       ovf_exc = 1'b0;
    logic       eret = 1'b0;
    logic       mask_we = 1'b0;
    logic [3:0] mask_wdata = '0;
    logic [8:0] pc;
    logic       bank_sel;
    logic       flush;
    logic [8:0] epc;
    logic [3:0] cause;
    logic [3:0] pending;
    logic       halted;

    int n_total = 0;
    int n_pass  = 0;

    exception_sequencer #(.NUM_IRQ(4), .ADDR_W(9), .VECTOR(0)) dut (
        .clk        (clk),
        .reset      (reset),
        .pc_next    (pc_next),
        .irq        (irq),
        .ovf_exc    (ovf_exc),
        .eret       (eret),
        .mask_we    (mask_we),
        .mask_wdata (mask_wdata),
        .pc         (pc),
        .bank_sel   (bank_sel),
        .flush      (flush),
        .epc        (epc),
        .cause      (cause),
        .pending    (pending),
        .halted     (halted)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [8:0] pn;
        logic [3:0] irq;
        logic       ovf;
        logic       er;
        logic       mwe;
        logic [3:0] mw;
        logic [8:0] e_pc;
        logic       e_bank;
        logic       e_flush;
        logic [8:0] e_epc;
        logic [3:0] e_cause;
        logic [3:0] e_pend;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t v(logic [8:0] pn, logic [3:0] ir, logic ovf, logic er,
                               logic mwe, logic [3:0] mw, logic [8:0] e_pc, logic e_bank,
                               logic e_flush, logic [8:0] e_epc, logic [3:0] e_cause,
                               logic [3:0] e_pend);
        vec_t r;
        r.pn = pn; r.irq = ir; r.ovf = ovf; r.er = er; r.mwe = mwe; r.mw = mw;
        r.e_pc = e_pc; r.e_bank = e_bank; r.e_flush = e_flush;
        r.e_epc = e_epc; r.e_cause = e_cause; r.e_pend = e_pend;
        return r;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic check_all(string tag, logic [8:0] e_pc, logic e_bank, logic e_flush,
                             logic [8:0] e_epc, logic [3:0] e_cause, logic [3:0] e_pend,
                             logic e_halt);
        check({tag, ".pc"},      32'(pc),       32'(e_pc));
        check({tag, ".bank"},    32'(bank_sel), 32'(e_bank));
        check({tag, ".flush"},   32'(flush),    32'(e_flush));
        check({tag, ".epc"},     32'(epc),      32'(e_epc));
        check({tag, ".cause"},   32'(cause),    32'(e_cause));
        check({tag, ".pending"}, 32'(pending),  32'(e_pend));
        check({tag, ".halted"},  32'(halted),   32'(e_halt));
    endtask

    initial begin
        // Each row: inputs driven for one cycle, expected outputs seen during
        // that cycle (registered state from the previous edge, flush comb).
        //            pn     irq   ov er we mw       pc    bk fl epc    cs     pend
        vecs.push_back(v(9'h010, 4'h0, 0, 0, 1, 4'b0001, 9'h000, 0, 0, 9'h000, 4'h0, 4'h0)); // r0 mask=0001
        vecs.push_back(v(9'h011, 4'h1, 0, 0, 0, 4'h0,    9'h010, 0, 0, 9'h000, 4'h0, 4'h0)); // r1 irq0 pulse
        vecs.push_back(v(9'h011, 4'h0, 0, 0, 0, 4'h0,    9'h011, 0, 0, 9'h000, 4'h0, 4'h1)); // r2 taken
        vecs.push_back(v(9'h001, 4'h0, 0, 0, 0, 4'h0,    9'h000, 1, 0, 9'h011, 4'h0, 4'h0)); // r3 vector
        vecs.push_back(v(9'h002, 4'h0, 0, 1, 0, 4'h0,    9'h001, 1, 0, 9'h011, 4'h0, 4'h0)); // r4 eret
        vecs.push_back(v(9'h012, 4'h0, 0, 0, 0, 4'h0,    9'h011, 0, 0, 9'h011, 4'h0, 4'h0)); // r5 RETURN
        vecs.push_back(v(9'h020, 4'h0, 0, 0, 0, 4'h0,    9'h012, 0, 0, 9'h011, 4'h0, 4'h0)); // r6
        vecs.push_back(v(9'h021, 4'h0, 1, 0, 0, 4'h0,    9'h020, 0, 1, 9'h011, 4'h0, 4'h0)); // r7 ovf
        vecs.push_back(v(9'h001, 4'h4, 0, 0, 1, 4'b0101, 9'h000, 1, 0, 9'h020, 4'hC, 4'h0)); // r8 irq2 in SERVICE
        vecs.push_back(v(9'h002, 4'h0, 0, 1, 0, 4'h0,    9'h001, 1, 0, 9'h020, 4'hC, 4'h4)); // r9 eret
        vecs.push_back(v(9'h021, 4'h0, 0, 0, 0, 4'h0,    9'h020, 0, 0, 9'h020, 4'hC, 4'h4)); // r10 RETURN blocks
        vecs.push_back(v(9'h022, 4'h0, 0, 0, 0, 4'h0,    9'h021, 0, 0, 9'h020, 4'hC, 4'h4)); // r11 take line2
        vecs.push_back(v(9'h001, 4'h0, 0, 0, 0, 4'h0,    9'h000, 1, 0, 9'h022, 4'h2, 4'h0)); // r12
        vecs.push_back(v(9'h002, 4'h6, 0, 0, 1, 4'b1111, 9'h001, 1, 0, 9'h022, 4'h2, 4'h0)); // r13 pend 0110
        vecs.push_back(v(9'h003, 4'h0, 0, 1, 0, 4'h0,    9'h002, 1, 0, 9'h022, 4'h2, 4'h6)); // r14 eret
        vecs.push_back(v(9'h023, 4'h0, 0, 0, 0, 4'h0,    9'h022, 0, 0, 9'h022, 4'h2, 4'h6)); // r15 RETURN
        vecs.push_back(v(9'h024, 4'h0, 0, 0, 0, 4'h0,    9'h023, 0, 0, 9'h022, 4'h2, 4'h6)); // r16 take line1
        vecs.push_back(v(9'h001, 4'h0, 0, 1, 0, 4'h0,    9'h000, 1, 0, 9'h024, 4'h1, 4'h4)); // r17 eret
        vecs.push_back(v(9'h025, 4'h0, 0, 0, 0, 4'h0,    9'h024, 0, 0, 9'h024, 4'h1, 4'h4)); // r18 RETURN
        vecs.push_back(v(9'h026, 4'h0, 0, 0, 0, 4'h0,    9'h025, 0, 0, 9'h024, 4'h1, 4'h4)); // r19 take line2
        vecs.push_back(v(9'h001, 4'h4, 0, 0, 0, 4'h0,    9'h000, 1, 0, 9'h026, 4'h2, 4'h0)); // r20 relatch irq2
        vecs.push_back(v(9'h002, 4'h0, 0, 1, 0, 4'h0,    9'h001, 1, 0, 9'h026, 4'h2, 4'h4)); // r21 eret
        vecs.push_back(v(9'h027, 4'h0, 1, 0, 0, 4'h0,    9'h026, 0, 1, 9'h026, 4'h2, 4'h4)); // r22 ovf in RETURN
        vecs.push_back(v(9'h001, 4'h0, 0, 1, 0, 4'h0,    9'h000, 1, 0, 9'h026, 4'hC, 4'h4)); // r23 eret
        vecs.push_back(v(9'h027, 4'h0, 0, 0, 0, 4'h0,    9'h026, 0, 0, 9'h026, 4'hC, 4'h4)); // r24 RETURN
        vecs.push_back(v(9'h028, 4'h4, 0, 0, 0, 4'h0,    9'h027, 0, 0, 9'h026, 4'hC, 4'h4)); // r25 take+set same bit
        vecs.push_back(v(9'h001, 4'h0, 0, 0, 1, 4'b0000, 9'h000, 1, 0, 9'h028, 4'h2, 4'h4)); // r26 set wins, mask=0
        vecs.push_back(v(9'h002, 4'h0, 0, 1, 0, 4'h0,    9'h001, 1, 0, 9'h028, 4'h2, 4'h4)); // r27 eret
        vecs.push_back(v(9'h029, 4'h0, 0, 0, 0, 4'h0,    9'h028, 0, 0, 9'h028, 4'h2, 4'h4)); // r28 RETURN
        vecs.push_back(v(9'h1FF, 4'h0, 0, 1, 0, 4'h0,    9'h029, 0, 0, 9'h028, 4'h2, 4'h4)); // r29 masked, eret ignored
        vecs.push_back(v(9'h02A, 4'h0, 0, 0, 1, 4'b0100, 9'h1FF, 0, 0, 9'h028, 4'h2, 4'h4)); // r30 mask write
        vecs.push_back(v(9'h02B, 4'h0, 0, 0, 0, 4'h0,    9'h02A, 0, 0, 9'h028, 4'h2, 4'h4)); // r31 mask live, take
        vecs.push_back(v(9'h001, 4'h0, 0, 0, 0, 4'h0,    9'h000, 1, 0, 9'h02B, 4'h2, 4'h0)); // r32

        // Reset state.
        #1 reset = 1'b1;
        #1 check_all("reset", 9'h000, 0, 0, 9'h000, 4'h0, 4'h0, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            if (i != 0) @(negedge clk);
            pc_next    = vecs[i].pn;
            irq        = vecs[i].irq;
            ovf_exc    = vecs[i].ovf;
            eret       = vecs[i].er;
            mask_we    = vecs[i].mwe;
            mask_wdata = vecs[i].mw;
            #1 check_all($sformatf("r%0d", i), vecs[i].e_pc, vecs[i].e_bank, vecs[i].e_flush,
                         vecs[i].e_epc, vecs[i].e_cause, vecs[i].e_pend, 0);
        end

        // Double fault in SERVICE (pc is 0x001 here); pc_next equals pc so the
        // faulting address is unambiguous.
        @(negedge clk);
        pc_next = 9'h001; irq = 4'h0; ovf_exc = 1'b1; eret = 1'b0; mask_we = 1'b0;
        #1 check_all("dfault", 9'h001, 1, 1, 9'h02B, 4'h2, 4'h0, 0);

        // HALT: frozen across 10 cycles regardless of pc_next/eret/ovf.
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            pc_next = 9'(9'h0A0 + k);
            ovf_exc = k[0];
            eret    = ~k[0];
            #1 check_all($sformatf("halt%0d", k), 9'h001, 1, 1, 9'h02B, 4'h2, 4'h0, 1);
        end

        // Asynchronous reset mid-cycle, no clock edge needed.
        #2 reset = 1'b1;
        ovf_exc = 1'b0; eret = 1'b0;
        #1 check_all("async_rst", 9'h000, 0, 0, 9'h000, 4'h0, 4'h0, 0);
        @(negedge clk);
        reset = 1'b0;
        pc_next = 9'h005;
        @(negedge clk);
        #1 check_all("post_rst", 9'h005, 0, 0, 9'h000, 4'h0, 4'h0, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
